prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/cpu_pkg.sv | 18 +
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared CPU constants and the program loader state type.
// Contents: INSTR_WIDTH, IMEM_DEPTH, loader_state_e.
package cpu_pkg;

   localparam int unsigned INSTR_WIDTH = 9;
   localparam int unsigned IMEM_DEPTH  = 512;

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_INS_LO,
      S_INS_HI,
      S_CSUM,
      S_DONE,
      S_ERR
   } loader_state_e;

endpackage : cpu_pkg

// File: rtl/prog_loader.sv
// Purpose: receive a length-prefixed, checksummed program byte stream and
//          write it into instruction memory, then release the core.
// Ports:
//   clk         - clock, all state changes on rising edge
//   start       - synchronous active-high reset / re-arm
//   in_valid    - byte available on in_data
//   in_data     - program stream byte
//   in_ready    - loader accepts a byte this cycle
//   imem_we     - instruction memory write strobe
//   imem_addr   - instruction memory write address
//   imem_wdata  - instruction word
//   done        - program loaded with good checksum (level)
//   core_start  - one-cycle pulse releasing the core
//   err         - bad length, bad high byte or checksum mismatch (level)
module prog_loader
   import cpu_pkg::*;
#(
   parameter int unsigned instr_width = INSTR_WIDTH,
   parameter int unsigned addr_width  = $clog2(IMEM_DEPTH)
) (
   input  logic                   clk,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   imem_we,
   output logic [addr_width-1:0]  imem_addr,
   output logic [instr_width-1:0] imem_wdata,
   output logic                   done,
   output logic                   core_start,
   output logic                   err
);

   localparam int unsigned IDX_W   = addr_width + 1;
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned MAX_LEN = 1 << addr_width;

   loader_state_e          state_q, state_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             csum_q, csum_d;
   logic [7:0]             lo_q, lo_d;
   logic                   we_q, we_d;
   logic [addr_width-1:0]  addr_q, addr_d;
   logic [instr_width-1:0] wdata_q, wdata_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   cs_q, cs_d;
   logic                   xfer;

   // Receive states accept unconditionally; nothing is consumed while start is high.
   assign in_ready = ~start && (state_q inside {S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CSUM});
   assign xfer     = in_valid && in_ready;

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      lo_d    = lo_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_LEN_LO: begin
            if (xfer) begin
               len_d   = {8'h00, in_data};
               csum_d  = csum_q ^ in_data;
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d  = {in_data, len_q[7:0]};
               csum_d = csum_q ^ in_data;
               if ((len_d == LEN_W'(0)) || (32'(len_d) > MAX_LEN)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_INS_LO;
               end
            end
         end
         S_INS_LO: begin
            if (xfer) begin
               lo_d    = in_data;
               csum_d  = csum_q ^ in_data;
               state_d = S_INS_HI;
            end
         end
         S_INS_HI: begin
            if (xfer) begin
               csum_d = csum_q ^ in_data;
               if (in_data[7:1] != 7'd0) begin
                  state_d = S_ERR;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = idx_q[addr_width-1:0];
                  wdata_d = instr_width'({in_data[0], lo_q});
                  idx_d   = idx_q + IDX_W'(1);
                  // Last pair when this write brings the count up to N.
                  if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
                     state_d = S_CSUM;
                  end else begin
                     state_d = S_INS_LO;
                  end
               end
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase

      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
      cs_d   = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // State and datapath registers with synchronous reset on start.
   always_ff @(posedge clk) begin
      if (start) begin
         state_q <= S_LEN_LO;
         len_q   <= '0;
         idx_q   <= '0;
         csum_q  <= 8'h00;
         lo_q    <= 8'h00;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         lo_q    <= lo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cs_q    <= cs_d;
      end
   end

   // A start arriving while a write or release is pending cancels it.
   assign imem_we    = we_q && ~start;
   assign core_start = cs_q && ~start;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Purpose: self-checking bench for prog_loader. A stream-level model derives
//          every expected output from the list of bytes accepted since the
//          last start; directed streams add hand-computed expectations.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       start = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, imem_we, done, core_start, err;
   logic [8:0] imem_addr;
   logic [8:0] imem_wdata;

   always #5 clk = ~clk;

   prog_loader #(.instr_width(9), .addr_width(9)) dut (
      .clk        (clk),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .done       (done),
      .core_start (core_start),
      .err        (err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stream-level reference model ----------------
   logic [7:0] mq[$];           // bytes accepted since last start
   int         m_st = 0;        // 0 loading, 1 done, 2 error
   int         m_nw = 0;
   bit         m_pend = 0;      // a write was produced by the last edge
   bit         m_entered = 0;   // done was reached at the last edge
   logic [8:0] m_addr = '0;
   logic [8:0] m_wdata = '0;
   bit         armed = 0;
   int         st0, nw0, st1, nw1;
   logic [7:0] hb, lb;

   // Outcome of a byte list: status and number of instructions written.
   function automatic void eval_stream(output int st, output int nw);
      int n;
      logic [7:0] x, b;
      st = 0;
      nw = 0;
      if (mq.size() < 2) return;
      n = int'(mq[1]) * 256 + int'(mq[0]);
      if (n == 0 || n > 512) begin
         st = 2;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (3 + 2 * i >= mq.size()) return;
         b = mq[3 + 2 * i];
         if (b > 8'h01) begin
            st = 2;
            return;
         end
         nw++;
      end
      if (2 + 2 * n >= mq.size()) return;
      x = 8'h00;
      for (int k = 0; k < 2 + 2 * n; k++) x = x ^ mq[k];
      st = (mq[2 + 2 * n] == x) ? 1 : 2;
   endfunction

   always @(posedge clk) begin
      if (start) begin
         mq.delete();
         m_st = 0; m_nw = 0; m_pend = 0; m_entered = 0;
         m_addr = '0; m_wdata = '0;
      end else begin
         eval_stream(st0, nw0);
         m_pend = 0;
         m_entered = 0;
         if (in_valid && st0 == 0) begin
            mq.push_back(in_data);
            eval_stream(st1, nw1);
            if (nw1 > nw0) begin
               hb = mq[mq.size() - 1];
               lb = mq[mq.size() - 2];
               m_pend  = 1;
               m_addr  = 9'(nw1 - 1);
               m_wdata = {hb[0], lb};
            end
            m_entered = (st1 == 1);
            m_st = st1;
            m_nw = nw1;
         end
      end
      armed = 1;
   end

   // ---------------- per-cycle compare and write log ----------------
   int         wr_cnt = 0;
   int         cs_cnt = 0;
   logic [8:0] last_addr = '0;
   logic [8:0] img[512];

   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready",   in_ready,   !start && m_st == 0);
         chk("imem_we",    imem_we,    m_pend && !start);
         chk("imem_addr",  imem_addr,  m_addr);
         chk("imem_wdata", imem_wdata, m_wdata);
         chk("done",       done,       m_st == 1);
         chk("err",        err,        m_st == 2);
         chk("core_start", core_start, m_entered && !start);
         if (imem_we === 1'b1) begin
            wr_cnt++;
            last_addr = imem_addr;
            img[imem_addr] = imem_wdata;
         end
         if (core_start === 1'b1) cs_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic s, input logic v, input logic [7:0] d);
      start = s; in_valid = v; in_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      step(1'b1, 1'($urandom), 8'($urandom));
      step(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic send(input logic [7:0] bs[$], input int gap, input int lim);
      for (int i = 0; i < bs.size() && i < lim; i++) begin
         repeat ($urandom_range(0, gap)) step(1'b0, 1'b0, 8'($urandom));
         step(1'b0, 1'b1, bs[i]);
      end
   endtask

   // Well-formed stream of n random instructions with correct checksum.
   task automatic mk(input int n, output logic [7:0] s[$]);
      logic [7:0] x;
      s = {};
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         s.push_back(8'($urandom));
         s.push_back(8'($urandom_range(0, 1)));
      end
      x = 8'h00;
      foreach (s[k]) x = x ^ s[k];
      s.push_back(x);
   endtask

   logic [7:0] s[$];
   int wb, cb, n, mode, p;

   initial begin
      step(1'b1, 1'b1, 8'hAA);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_ready", in_ready, 1);

      // Good two-instruction program.
      wb = wr_cnt; cb = cs_cnt;
      s = '{8'h02, 8'h00, 8'h13, 8'h01, 8'hA5, 8'h00, 8'hB5};
      send(s, 0, 100);
      repeat (2) step(1'b0, 1'b0, 8'h00);
      chk("d1_writes", wr_cnt - wb, 2);
      chk("d1_img0", img[0], 9'h113);
      chk("d1_img1", img[1], 9'h0A5);
      chk("d1_done", done, 1);
      chk("d1_cs", cs_cnt - cb, 1);

      // Same stream, wrong checksum.
      do_start();
      wb = wr_cnt; cb = cs_cnt;
      s = '{8'h02, 8'h00, 8'h13, 8'h01, 8'hA5, 8'h00, 8'hB4};
      send(s, 1, 100);
      repeat (2) step(1'b0, 1'b1, 8'h55);
      chk("d2_writes", wr_cnt - wb, 2);
      chk("d2_err", err, 1);
      chk("d2_done", done, 0);
      chk("d2_cs", cs_cnt - cb, 0);

      // Zero length and oversize length.
      do_start();
      wb = wr_cnt;
      s = '{8'h00, 8'h00, 8'h13, 8'h01};
      send(s, 0, 100);
      chk("d3_err", err, 1);
      chk("d3_ready", in_ready, 0);
      chk("d3_writes", wr_cnt - wb, 0);
      do_start();
      s = '{8'h01, 8'h02, 8'h13, 8'h01};
      send(s, 0, 100);
      chk("d4_err", err, 1);
      chk("d4_writes", wr_cnt - wb, 0);

      // Illegal high byte on the second pair.
      do_start();
      wb = wr_cnt;
      s = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h55, 8'h03, 8'h00};
      send(s, 0, 100);
      step(1'b0, 1'b0, 8'h00);
      chk("d5_writes", wr_cnt - wb, 1);
      chk("d5_last", last_addr, 0);
      chk("d5_err", err, 1);

      // Full-depth program with in_valid held high.
      do_start();
      wb = wr_cnt;
      mk(512, s);
      send(s, 0, 10000);
      step(1'b0, 1'b0, 8'h00);
      chk("d6_writes", wr_cnt - wb, 512);
      chk("d6_last", last_addr, 9'h1FF);
      chk("d6_done", done, 1);

      // Abort right after an INS_HI transfer, then reload.
      do_start();
      wb = wr_cnt;
      s = '{8'h02, 8'h00, 8'h13, 8'h01};
      send(s, 0, 100);
      step(1'b1, 1'b1, 8'hA5);
      chk("d7_abort_writes", wr_cnt - wb, 0);
      step(1'b0, 1'b0, 8'h00);
      s = '{8'h02, 8'h00, 8'h13, 8'h01, 8'hA5, 8'h00, 8'hB5};
      send(s, 0, 100);
      step(1'b0, 1'b0, 8'h00);
      chk("d7_writes", wr_cnt - wb, 2);
      chk("d7_img0", img[0], 9'h113);
      chk("d7_done", done, 1);

      // Randomised streams with corruptions, gaps and aborts.
      for (int it = 0; it < 40; it++) begin
         do_start();
         n = $urandom_range(1, 12);
         mk(n, s);
         mode = $urandom_range(0, 4);
         case (mode)
            1: s[s.size() - 1] = s[s.size() - 1] ^ 8'(1 << $urandom_range(0, 7));
            2: begin
               p = $urandom_range(0, n - 1);
               s[3 + 2 * p] = 8'h02 | 8'($urandom);
            end
            3: begin
               if ($urandom_range(0, 1) == 0) begin
                  s[0] = 8'h00; s[1] = 8'h00;
               end else begin
                  s[0] = 8'($urandom); s[1] = 8'($urandom_range(2, 255));
               end
            end
            default: ;
         endcase
         send(s, 2, (mode == 4) ? int'($urandom_range(1, s.size() - 1)) : 1000);
         repeat (2) step(1'b0, 1'($urandom), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_prog_loader
